// File: rtl/cen_gen.sv
// cen_gen: multi-channel fractional clock-enable generator; CEN_GEN_STAT_EN adds per-channel pulse counters
module cen_gen #(
   parameter int NUM_CH = 3,
   parameter int ACC_W = 16,
   parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {16'd1, 16'd1, 16'd1},
   parameter logic [NUM_CH*ACC_W-1:0] MOD_INIT = {16'd10, 16'd41, 16'd10}
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              cfg_wr,
   input  logic [3:0]        cfg_addr,
   input  logic              cfg_sel,
   input  logic [ACC_W-1:0]  cfg_data,
   output logic              cfg_err,
   input  logic [NUM_CH-1:0] hold,
   input  logic              restart,
   output logic [NUM_CH-1:0] cen
`ifdef CEN_GEN_STAT_EN
   ,
   input  logic [3:0]        stat_addr,
   output logic [15:0]       stat_count
`endif
);
   logic [ACC_W-1:0] inc_a [NUM_CH];
   logic [ACC_W-1:0] mod_a [NUM_CH];
   logic [ACC_W-1:0] inc_s [NUM_CH];
   logic [ACC_W-1:0] mod_s [NUM_CH];
   logic [ACC_W:0]   acc   [NUM_CH];
   logic [ACC_W:0]   sum   [NUM_CH];
   logic [NUM_CH-1:0] hit;
   logic [ACC_W-1:0] cur_inc;
   logic [ACC_W-1:0] cur_mod;
   logic addr_ok;
   logic wr_bad;
   logic wr_ok;

   // one add and one compare per channel against the active modulus
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         sum[i] = acc[i] + {1'b0, inc_a[i]};
         hit[i] = sum[i] >= {1'b0, mod_a[i]};
      end
   end

   // a write is judged against the addressed channel's shadow pair so shadow stays inc <= mod
   always_comb begin
      cur_inc = '0;
      cur_mod = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_addr == 4'(i)) begin
            cur_inc = inc_s[i];
            cur_mod = mod_s[i];
         end
      end
      addr_ok = {1'b0, cfg_addr} < 5'(NUM_CH);
      wr_bad = cfg_wr && (!addr_ok || cfg_data == '0 || (cfg_sel ? cfg_data < cur_inc : cfg_data > cur_mod));
      wr_ok = cfg_wr && !wr_bad;
   end

   // channel state: shadow writes, then restart over hold over pulse over plain counting
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            inc_a[i] <= INC_INIT[i*ACC_W +: ACC_W];
            inc_s[i] <= INC_INIT[i*ACC_W +: ACC_W];
            mod_a[i] <= MOD_INIT[i*ACC_W +: ACC_W];
            mod_s[i] <= MOD_INIT[i*ACC_W +: ACC_W];
            acc[i] <= '0;
         end
         cen <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= wr_bad;
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ok && cfg_addr == 4'(i)) begin
               if (cfg_sel) mod_s[i] <= cfg_data;
               else inc_s[i] <= cfg_data;
            end
            if (restart || hold[i] || hit[i]) begin
               inc_a[i] <= inc_s[i];
               mod_a[i] <= mod_s[i];
            end
            acc[i] <= restart ? '0 : hold[i] ? acc[i] : hit[i] ? sum[i] - {1'b0, mod_a[i]} : sum[i];
            cen[i] <= !restart && !hold[i] && hit[i];
         end
      end
   end

`ifdef CEN_GEN_STAT_EN
   logic [15:0] cnt [NUM_CH];
   logic [15:0] cnt_sel;

   // wrapping count of emitted pulses per channel
   always_ff @(posedge clk_sys) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!reset_n || restart) cnt[i] <= '0;
         else if (!hold[i] && hit[i]) cnt[i] <= cnt[i] + 16'd1;
      end
   end

   // read mux; unused addresses read as zero
   always_comb begin
      cnt_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (stat_addr == 4'(i)) cnt_sel = cnt[i];
      end
   end

   // registered read port
   always_ff @(posedge clk_sys) begin
      stat_count <= !reset_n ? '0 : cnt_sel;
   end
`endif
endmodule
